// File: rtl/vram_arbiter.sv
// Video RAM arbiter. The display fetch path owns the RAM whenever it asks;
// processor writes are posted through a small FIFO and processor reads wait
// until every earlier posted write has reached memory.
module vram_arbiter #(
    parameter int unsigned AW           = 12,
    parameter int unsigned DW           = 8,
    parameter int unsigned WFIFO_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          starve_err
);

    localparam int unsigned PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FIFO_FULL  = WFIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] STARVE_MAX = STARVE_LIMIT[CW-1:0];

    typedef enum logic [1:0] {StIdle, StRdWait, StRdData, StRdAck} rd_state_e;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic [AW-1:0] rd_addr_q;
    logic          wr_ack_q;
    logic          disp_valid_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q;

    logic fifo_empty, fifo_full, is_idle;
    logic wr_accept, rd_accept, wr_gnt, rd_gnt, cpu_gnt, pending;

    assign fifo_empty = (count_q == '0);
    // Full uses the pre-edge count, so a same-cycle pop never frees a slot early.
    assign fifo_full  = (count_q == FIFO_FULL);
    assign is_idle    = (state_q == StIdle);

    assign cpu_ack   = wr_ack_q | (state_q == StRdAck);
    assign wr_accept = cpu_req & cpu_we & ~cpu_ack & ~fifo_full & is_idle;
    assign rd_accept = cpu_req & ~cpu_we & ~cpu_ack & is_idle;

    // Display beats everything; reads only go once the write FIFO is drained.
    assign wr_gnt  = ~disp_req & ~fifo_empty;
    assign rd_gnt  = ~disp_req & fifo_empty & (state_q == StRdWait);
    assign cpu_gnt = wr_gnt | rd_gnt;
    assign pending = ~fifo_empty | (state_q == StRdWait);

    assign disp_valid = disp_valid_q;
    assign disp_rdata = mem_rdata;
    assign cpu_rdata  = cpu_rdata_q;
    assign starve_err = starve_q;

    // Memory port mux; forced quiet while reset is asserted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            if (disp_req) begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end else if (wr_gnt) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr_q[rd_ptr_q];
                mem_wdata = fifo_data_q[rd_ptr_q];
            end else if (rd_gnt) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr_q;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (rd_accept) state_d = StRdWait;
            StRdWait: if (rd_gnt) state_d = StRdData;
            StRdData: state_d = StRdAck;
            StRdAck:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (wr_accept && !wr_gnt) begin
            count_d = count_q + 1'b1;
        end else if (!wr_accept && wr_gnt) begin
            count_d = count_q - 1'b1;
        end
    end

    // Starvation counter: clears on any processor grant, saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (cpu_gnt) begin
            starve_cnt_d = '0;
        end else if (pending && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Control state, pointers, acks and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_addr_q    <= '0;
            wr_ack_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ack_q     <= wr_accept;
            disp_valid_q <= disp_req;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_q | (starve_cnt_d == STARVE_MAX);
            if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wr_gnt) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_accept) rd_addr_q <= cpu_addr;
            if (state_q == StRdData) cpu_rdata_q <= mem_rdata;
        end
    end

    // FIFO storage; contents are meaningless once the count is cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural RAM model.
module tb_vram_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_rdata;
    logic          disp_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          starve_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW(AW),
        .DW(DW),
        .WFIFO_DEPTH(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .disp_req(disp_req),
        .disp_addr(disp_addr),
        .disp_rdata(disp_rdata),
        .disp_valid(disp_valid),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .starve_err(starve_err)
    );

    // Single-port synchronous RAM: read data appears one cycle after the access.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ram[12'h010] <= 8'h3C;

        // Reset state, with a display request present to prove mem_en is gated.
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        #1 rst = 1'b0;
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_starve", 32'(starve_err), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        do_reset();

        // Display fetch for 3 cycles.
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("disp_mem_en", 32'(mem_en), 1);
            check("disp_mem_we", 32'(mem_we), 0);
            check("disp_mem_addr", 32'(mem_addr), 'h010);
            check("disp_valid", 32'(disp_valid), (i == 0) ? 0 : 1);
            if (i > 0) check("disp_rdata", 32'(disp_rdata), 'h3C);
            cyc();
        end
        disp_req = 1'b0;
        #1;
        check("disp_valid_tail", 32'(disp_valid), 1);
        check("disp_rdata_tail", 32'(disp_rdata), 'h3C);
        check("disp_idle_en", 32'(mem_en), 0);
        cyc();
        #1;
        check("disp_valid_end", 32'(disp_valid), 0);

        // Single posted write, no display traffic.
        cyc();
        set_write(12'h020, 8'h5A);
        #1;
        check("wr_ack_early", 32'(cpu_ack), 0);
        check("wr_en_early", 32'(mem_en), 0);
        cyc();
        cpu_req = 1'b0;
        #1;
        check("wr_ack", 32'(cpu_ack), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", 32'(mem_addr), 'h020);
        check("wr_mem_wdata", 32'(mem_wdata), 'h5A);
        cyc();
        #1;
        check("wr_ack_drop", 32'(cpu_ack), 0);
        check("wr_en_drop", 32'(mem_en), 0);

        // Fill the FIFO under display load, then a 5th write stalls.
        cyc();
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        for (int k = 0; k < 4; k++) begin
            set_write(12'(32'h040 + k), 8'(32'h11 + k));
            #1;
            check("fill_ack_early", 32'(cpu_ack), 0);
            check("fill_we", 32'(mem_we), 0);
            cyc();
            cpu_req = 1'b0;
            #1;
            check("fill_ack", 32'(cpu_ack), 1);
            check("fill_we_ack", 32'(mem_we), 0);
            cyc();
        end
        set_write(12'h044, 8'h15);
        for (int j = 0; j < 3; j++) begin
            #1;
            check("full_no_ack", 32'(cpu_ack), 0);
            check("full_we", 32'(mem_we), 0);
            cyc();
        end
        disp_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drain_we", 32'(mem_we), 1);
            check("drain_addr", 32'(mem_addr), 32'h040 + k);
            check("drain_wdata", 32'(mem_wdata), 32'h11 + k);
            // The first pop frees a slot; the stalled write is acked two cycles in.
            check("drain_ack", 32'(cpu_ack), (k == 2) ? 1 : 0);
            if (k == 2) cpu_req = 1'b0;
            cyc();
        end
        #1;
        check("drain_done", 32'(mem_en), 0);

        // Read ordered behind a posted write, under display load.
        do_reset();
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        set_write(12'h030, 8'hA5);
        #1;
        check("rw_we_blocked", 32'(mem_we), 0);
        cyc();
        cpu_req = 1'b0;
        #1;
        check("rw_wr_ack", 32'(cpu_ack), 1);
        cyc();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h030;
        #1;
        check("rw_accept_ack", 32'(cpu_ack), 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rw_wait_ack", 32'(cpu_ack), 0);
            check("rw_wait_we", 32'(mem_we), 0);
            cyc();
        end
        disp_req = 1'b0;
        #1;
        check("rw_drain_we", 32'(mem_we), 1);
        check("rw_drain_addr", 32'(mem_addr), 'h030);
        check("rw_drain_wdata", 32'(mem_wdata), 'hA5);
        cyc();
        #1;
        check("rw_rd_en", 32'(mem_en), 1);
        check("rw_rd_we", 32'(mem_we), 0);
        check("rw_rd_addr", 32'(mem_addr), 'h030);
        check("rw_rd_ack_early", 32'(cpu_ack), 0);
        cyc();
        #1;
        check("rw_data_ack_early", 32'(cpu_ack), 0);
        cyc();
        #1;
        check("rw_ack", 32'(cpu_ack), 1);
        check("rw_rdata", 32'(cpu_rdata), 'hA5);
        check("rw_no_starve", 32'(starve_err), 0);
        cpu_req = 1'b0;
        cyc();
        #1;
        check("rw_ack_drop", 32'(cpu_ack), 0);
        check("rw_idle_en", 32'(mem_en), 0);

        // Starvation: one posted write blocked by constant display traffic.
        do_reset();
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        set_write(12'h050, 8'h77);
        cyc();
        cpu_req = 1'b0;
        #1;
        check("st_ack", 32'(cpu_ack), 1);
        check("st_err_early", 32'(starve_err), 0);
        cyc();
        for (int i = 0; i < 7; i++) begin
            #1;
            check("st_err_pre", 32'(starve_err), 0);
            cyc();
        end
        #1;
        check("st_err_set", 32'(starve_err), 1);
        cyc();
        disp_req = 1'b0;
        #1;
        check("st_drain_we", 32'(mem_we), 1);
        check("st_drain_addr", 32'(mem_addr), 'h050);
        check("st_err_hold", 32'(starve_err), 1);
        cyc();
        #1;
        check("st_err_sticky", 32'(starve_err), 1);
        check("st_idle_en", 32'(mem_en), 0);

        // Asynchronous reset while a read waits behind two posted writes.
        do_reset();
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        set_write(12'h060, 8'h01);
        cyc();
        cpu_req = 1'b0;
        #1;
        check("ar_ack0", 32'(cpu_ack), 1);
        cyc();
        set_write(12'h061, 8'h02);
        cyc();
        cpu_req = 1'b0;
        #1;
        check("ar_ack1", 32'(cpu_ack), 1);
        cyc();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 12'h062;
        cyc();
        #1;
        check("ar_pre_en", 32'(mem_en), 1);
        check("ar_pre_valid", 32'(disp_valid), 1);
        rst = 1'b0;
        #1;
        check("ar_cpu_ack", 32'(cpu_ack), 0);
        check("ar_disp_valid", 32'(disp_valid), 0);
        check("ar_mem_en", 32'(mem_en), 0);
        check("ar_mem_we", 32'(mem_we), 0);
        check("ar_mem_addr", 32'(mem_addr), 0);
        check("ar_mem_wdata", 32'(mem_wdata), 0);
        check("ar_cpu_rdata", 32'(cpu_rdata), 0);
        check("ar_starve", 32'(starve_err), 0);
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("ar_post_ack", 32'(cpu_ack), 0);
            check("ar_post_we", 32'(mem_we), 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
